// File: rtl/addsub_seq_ctrl_if.sv
// Handshake bundle for the multi-cycle add/sub sequencer.
// Master issues operands and takes results; slave is the sequencer.
interface addsub_seq_ctrl_if #(
   parameter int NSLICE = 4
);
   localparam int W = 16 * NSLICE;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero
   );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract built from one 16-bit slice reused per cycle,
// LSB slice first, with the carry chained through a register.
module addsub_seq_ctrl #(
   parameter int NSLICE = 4
) (
   input logic              clk,
   input logic              rst_n,
   addsub_seq_ctrl_if.slave bus
);
   localparam int W  = 16 * NSLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [KW-1:0] k;
   logic          carry;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          sub_q;
   logic [W-1:0]  res_q;
   logic          cout_q;
   logic          ovf_q;
   logic          zero_q;

   logic [15:0]   a_sl;
   logic [15:0]   b_sl;
   logic [15:0]   s_sl;
   logic          c_sl;
   logic          last;
   logic [W-1:0]  res_n;
   logic          accept;

   // One 16-bit slice: operand inversion follows the latched sub bit,
   // while the carry-in is the chained register (sub for slice 0).
   always_comb begin
      a_sl  = a_q[{k, 4'b0} +: 16];
      b_sl  = b_q[{k, 4'b0} +: 16];
      {c_sl, s_sl} = {1'b0, a_sl}
                   + {1'b0, b_sl ^ {16{sub_q}}}
                   + {16'b0, carry};
      res_n = res_q;
      res_n[{k, 4'b0} +: 16] = s_sl;
      last  = (k == KW'(NSLICE - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (last) state_n = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand capture, slice stepping and flag capture on the last slice.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k      <= '0;
         carry  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sub_q  <= 1'b0;
         res_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         sub_q <= bus.sub;
         k     <= '0;
         carry <= bus.sub;
      end else if (state == RUN) begin
         res_q <= res_n;
         carry <= c_sl;
         k     <= last ? '0 : k + 1'b1;
         if (last) begin
            cout_q <= c_sl ^ sub_q;
            ovf_q  <= (a_sl[15] == (b_sl[15] ^ sub_q))
                   && (s_sl[15] != a_sl[15]);
            zero_q <= (res_n == '0);
         end
      end
   end

   assign bus.result   = res_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;

endmodule
